// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Holds the FSM state encoding, op selects and the iteration count.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITERATIONS = 32;
  localparam int CNT_W      = $clog2(ITERATIONS);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes:
// shift the next dividend bit into the remainder, trial-subtract, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  // The remainder is always below the divisor, so a borrow shows up in the top bit.
  always_comb begin
    rem_out = shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring on magnitudes).
// Fixed 34-cycle latency; divide-by-zero completes immediately without touching hi/lo.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_reg;
  logic             rem_neg;
  logic             quo_neg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH:0]   work_hi;
  logic [WIDTH-1:0] work_lo;
  logic             qm1;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign m_ext = {m_reg[WIDTH-1], m_reg};

  // Booth recoding of the multiplier LSB pair; one guard bit keeps -(-2^31) representable.
  always_comb begin
    booth_sum = work_hi;
    case ({work_lo[0], qm1})
      2'b01:   booth_sum = work_hi + m_ext;
      2'b10:   booth_sum = work_hi - m_ext;
      default: booth_sum = work_hi;
    endcase
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (work_hi[WIDTH-1:0]),
    .quo_in  (work_lo),
    .divisor (m_reg),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_reg   <= OP_MULT;
      rem_neg  <= 1'b0;
      quo_neg  <= 1'b0;
      m_reg    <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      qm1      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start) begin
            if (op == OP_DIV && b == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state   <= RUN;
              busy    <= 1'b1;
              cnt     <= '0;
              op_reg  <= op;
              rem_neg <= a[WIDTH-1];
              quo_neg <= a[WIDTH-1] ^ b[WIDTH-1];
              qm1     <= 1'b0;
              work_hi <= '0;
              if (op == OP_DIV) begin
                m_reg   <= b_mag;
                work_lo <= a_mag;
              end else begin
                m_reg   <= a;
                work_lo <= b;
              end
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_reg == OP_DIV) begin
            work_hi <= {1'b0, rem_next};
            work_lo <= quo_next;
          end else begin
            work_hi <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            work_lo <= {booth_sum[0], work_lo[WIDTH-1:1]};
            qm1     <= work_lo[0];
          end
          if (cnt == CNT_W'(ITERATIONS - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (op_reg == OP_DIV) begin
            hi <= rem_neg ? -work_hi[WIDTH-1:0] : work_hi[WIDTH-1:0];
            lo <= quo_neg ? -work_lo : work_lo;
          end else begin
            hi <= work_hi[WIDTH-1:0];
            lo <= work_lo;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: table of operations plus
// hand-written sequences for busy-time interference and mid-run reset.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Drives one request in IDLE and waits (bounded) for done; cycle 1 is the one after the accepting edge.
  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int busy_cyc, output logic got_dz, output logic timeout);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_cyc = 0; got_dz = 1'b0; timeout = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        lat = i; got_dz = div_zero; timeout = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int lat, busy_cyc;
    logic got_dz, timeout;
    logic [31:0] exp_lat, exp_busy;

    vecs[0]  = '{1'b0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[4]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[5]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[6]  = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[7]  = '{1'b1, 32'd5,        32'd0,        32'd2,        32'd14,       1'b1};
    vecs[8]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[9]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[11] = '{1'b1, 32'd3,        32'd10,       32'd3,        32'd0,        1'b0};
    vecs[12] = '{1'b1, 32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000, 1'b0};
    vecs[13] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b0};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dz", div_zero, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_cyc, got_dz, timeout);
      exp_lat  = vecs[i].exp_dz ? 32'd1 : 32'd34;
      exp_busy = vecs[i].exp_dz ? 32'd0 : 32'd33;
      $display("vec %0d op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dz=%0d lat=%0d busy=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, got_dz, lat, busy_cyc);
      check($sformatf("vec%0d_timeout", i), timeout, 0);
      check($sformatf("vec%0d_latency", i), lat, exp_lat);
      check($sformatf("vec%0d_busy_cycles", i), busy_cyc, exp_busy);
      check($sformatf("vec%0d_div_zero", i), got_dz, vecs[i].exp_dz);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_dz_pulse", i), div_zero, 0);
    end

    // Start and operands churn while busy; the accepted 100/7 must be unaffected.
    @(negedge clk);
    op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; timeout = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin lat = i; timeout = 1'b0; break; end
      start = (i > 3);
      op    = i[0];
      a     = $urandom;
      b     = $urandom_range(0, 3);
    end
    start = 1'b0;
    $display("busy churn: hi=0x%08h lo=0x%08h lat=%0d", hi, lo, lat);
    check("churn_timeout", timeout, 0);
    check("churn_latency", lat, 34);
    check("churn_hi", hi, 32'd2);
    check("churn_lo", lo, 32'd14);
    @(negedge clk);
    check("churn_no_restart_busy", busy, 0);

    // Reset at RUN cycle 10 aborts with no done pulse.
    @(negedge clk);
    op = 1'b0; a = 32'h12345678; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    $display("reset mid-run: busy=%0d done=%0d dz=%0d hi=0x%08h lo=0x%08h", busy, done, div_zero, hi, lo);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dz", div_zero, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("abort_no_done", seen, 0);
    end

    do_op(1'b0, 32'd6, 32'd7, lat, busy_cyc, got_dz, timeout);
    $display("after reset 6x7: hi=0x%08h lo=0x%08h lat=%0d", hi, lo, lat);
    check("post_reset_timeout", timeout, 0);
    check("post_reset_latency", lat, 34);
    check("post_reset_hi", hi, 0);
    check("post_reset_lo", lo, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
